lcd_grid_engine: RTL and testbench

//  Parametrised grid-drawing engine for the SPI LCD path. Generalises the fixed

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_pixel_scan.sv | 83 ++++++++
 rtl/lcd_grid_engine.sv | 144 ++++++++++++++
 tb/tb_lcd_grid_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared opcodes, D/C encodings, FSM state type and colour type for the LCD grid engine.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET_C,
    ST_CASET_D,
    ST_RASET_C,
    ST_RASET_D,
    ST_RAMWR_C,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DONE
  } lcd_state_e;

  typedef logic [15:0] rgb565_t;

  // Window argument bytes are start=0x0000 then end=last, each MSB first.
  function automatic logic [7:0] window_byte(input logic [1:0] idx, input logic [15:0] last);
    case (idx)
      2'd2:    window_byte = last[15:8];
      2'd3:    window_byte = last[7:0];
      default: window_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_pixel_scan.sv
// Raster pixel position and grid-cell tracker; yields the colour of the current pixel.
// LCD_GRID_LINES_EN selects grid-line colouring on cell edges and the closing border.
module lcd_pixel_scan
  import lcd_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int CELLS_X = 4,
  parameter int CELLS_Y = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    advance,
  input  rgb565_t color_a,
  input  rgb565_t color_b,
  input  rgb565_t line_color,
  output logic    last_pixel,
  output rgb565_t color
);

  localparam int CELL_W = WIDTH / CELLS_X;
  localparam int CELL_H = HEIGHT / CELLS_Y;
  localparam int CXW    = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int CYW    = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
  localparam logic [15:0] X_LAST  = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(HEIGHT - 1);
  localparam logic [15:0] OX_LAST = 16'(CELL_W - 1);
  localparam logic [15:0] OY_LAST = 16'(CELL_H - 1);

  logic [15:0]    x, y, ox, oy;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;

  // Offsets wrap at the cell size so the cell index never needs a divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0; y <= '0; ox <= '0; oy <= '0; cx <= '0; cy <= '0;
    end else if (clear) begin
      x <= '0; y <= '0; ox <= '0; oy <= '0; cx <= '0; cy <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x  <= '0;
        ox <= '0;
        cx <= '0;
        if (y == Y_LAST) begin
          y  <= '0;
          oy <= '0;
          cy <= '0;
        end else begin
          y <= y + 16'd1;
          if (oy == OY_LAST) begin
            oy <= '0;
            cy <= cy + CYW'(1);
          end else begin
            oy <= oy + 16'd1;
          end
        end
      end else begin
        x <= x + 16'd1;
        if (ox == OX_LAST) begin
          ox <= '0;
          cx <= cx + CXW'(1);
        end else begin
          ox <= ox + 16'd1;
        end
      end
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

`ifdef LCD_GRID_LINES_EN
  logic on_line;
  assign on_line = (ox == 16'd0) || (oy == 16'd0) || (x == X_LAST) || (y == Y_LAST);
  assign color   = on_line ? line_color : ((cx[0] ^ cy[0]) ? color_b : color_a);
`else
  logic unused_line_color;
  assign unused_line_color = ^line_color;
  assign color             = (cx[0] ^ cy[0]) ? color_b : color_a;
`endif

endmodule

// File: rtl/lcd_grid_engine.sv
// Grid-drawing engine: emits CASET/RASET/RAMWR then a full-panel RGB565 checkerboard as a
// valid/ready command/data byte stream. Optional grid lines via LCD_GRID_LINES_EN.
module lcd_grid_engine
  import lcd_pkg::*;
#(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int CELLS_X = 4,
  parameter int CELLS_Y = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_start,
  input  logic       abort,
  input  rgb565_t    color_a,
  input  rgb565_t    color_b,
  input  rgb565_t    line_color,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done,
  output lcd_state_e dbg_state
);

  if (WIDTH % CELLS_X != 0) begin : g_bad_cells_x
    $error("lcd_grid_engine: WIDTH must be a multiple of CELLS_X");
  end
  if (HEIGHT % CELLS_Y != 0) begin : g_bad_cells_y
    $error("lcd_grid_engine: HEIGHT must be a multiple of CELLS_Y");
  end

  localparam logic [15:0] W_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST = 16'(HEIGHT - 1);

  // Handshake: a byte moves when byte_valid && byte_ready at a rising clk edge; while
  // byte_valid is high and byte_ready low, byte_data/byte_dc are held (they decode
  // only registered state, which advances solely on a transfer).
  lcd_state_e state, state_n;
  logic [1:0] idx, idx_n;
  rgb565_t    ca_q, cb_q, cl_q, pix_color;
  logic       xfer, start, kill, last_pixel;

  assign xfer  = byte_valid && byte_ready;
  assign start = (state == ST_IDLE) && draw_start && !abort;
  assign kill  = abort && busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      ST_IDLE:    if (start) state_n = ST_CASET_C;
      ST_CASET_C: if (xfer) state_n = ST_CASET_D;
      ST_CASET_D: if (xfer) begin
        idx_n = idx + 2'd1;
        if (idx == 2'd3) state_n = ST_RASET_C;
      end
      ST_RASET_C: if (xfer) state_n = ST_RASET_D;
      ST_RASET_D: if (xfer) begin
        idx_n = idx + 2'd1;
        if (idx == 2'd3) state_n = ST_RAMWR_C;
      end
      ST_RAMWR_C: if (xfer) state_n = ST_PIX_HI;
      ST_PIX_HI:  if (xfer) state_n = ST_PIX_LO;
      ST_PIX_LO:  if (xfer) state_n = last_pixel ? ST_DONE : ST_PIX_HI;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    if (kill) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_dc    = DC_CMD;
    case (state)
      ST_CASET_C: begin byte_valid = 1'b1; byte_data = LCD_CMD_CASET; end
      ST_CASET_D: begin byte_valid = 1'b1; byte_dc = DC_DATA; byte_data = window_byte(idx, W_LAST); end
      ST_RASET_C: begin byte_valid = 1'b1; byte_data = LCD_CMD_RASET; end
      ST_RASET_D: begin byte_valid = 1'b1; byte_dc = DC_DATA; byte_data = window_byte(idx, H_LAST); end
      ST_RAMWR_C: begin byte_valid = 1'b1; byte_data = LCD_CMD_RAMWR; end
      ST_PIX_HI:  begin byte_valid = 1'b1; byte_dc = DC_DATA; byte_data = pix_color[15:8]; end
      ST_PIX_LO:  begin byte_valid = 1'b1; byte_dc = DC_DATA; byte_data = pix_color[7:0]; end
      default:    ;
    endcase
  end

  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ca_q <= '0;
      cb_q <= '0;
    end else if (start) begin
      ca_q <= color_a;
      cb_q <= color_b;
    end
  end

`ifdef LCD_GRID_LINES_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cl_q <= '0;
    else if (start) cl_q <= line_color;
  end
`else
  logic unused_line_color;
  assign unused_line_color = ^line_color;
  assign cl_q              = '0;
`endif

  lcd_pixel_scan #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CELLS_X(CELLS_X),
    .CELLS_Y(CELLS_Y)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .clear     (start || kill),
    .advance   ((state == ST_PIX_LO) && xfer),
    .color_a   (ca_q),
    .color_b   (cb_q),
    .line_color(cl_q),
    .last_pixel(last_pixel),
    .color     (pix_color)
  );

endmodule

// File: tb/tb_lcd_grid_engine.sv
// Directed bench for lcd_grid_engine on an 8x4 panel with 2x2 cells.
module tb_lcd_grid_engine;
  import lcd_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CX = 2;
  localparam int CY = 2;
  localparam int NB = 11 + 2 * W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       draw_start = 1'b0;
  logic       abort = 1'b0;
  rgb565_t    color_a = '0, color_b = '0, line_color = '0;
  logic       byte_valid, byte_dc, byte_ready = 1'b0, busy, done;
  logic [7:0] byte_data;
  lcd_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  lcd_grid_engine #(.WIDTH(W), .HEIGHT(H), .CELLS_X(CX), .CELLS_Y(CY)) dut (
    .clk(clk), .reset(reset), .draw_start(draw_start), .abort(abort),
    .color_a(color_a), .color_b(color_b), .line_color(line_color),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .byte_ready(byte_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic rgb565_t model_color(input int x, input int y, input rgb565_t a,
                                          input rgb565_t b, input rgb565_t l);
    int cx, cy;
    bit on_line;
    cx = x / (W / CX);
    cy = y / (H / CY);
`ifdef LCD_GRID_LINES_EN
    on_line = (x % (W / CX) == 0) || (y % (H / CY) == 0) || (x == W - 1) || (y == H - 1);
`else
    on_line = 1'b0;
`endif
    if (on_line) return l;
    return (((cx ^ cy) & 1) != 0) ? b : a;
  endfunction

  task automatic push_frame(input rgb565_t a, input rgb565_t b, input rgb565_t l);
    rgb565_t c;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'((W - 1) >> 8)});
    exp_q.push_back({1'b1, 8'((W - 1) & 255)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'((H - 1) >> 8)});
    exp_q.push_back({1'b1, 8'((H - 1) & 255)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        c = model_color(x, y, a, b, l);
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endtask

  // ---------------- driver ----------------
  // stop_mode: 0 = run to done, 1 = abort after stop_at transfers, 2 = reset after stop_at.
  task automatic run_frame(input int ready_pct, input int stop_at, input int stop_mode,
                           input bit poke);
    int n;
    int cyc;
    bit held;
    bit rdy;
    bit fin;
    logic [8:0] held_v;
    n = 0; cyc = 0; held = 0; fin = 0; held_v = '0;
    got.delete();
    @(negedge clk) draw_start = 1'b1;
    @(negedge clk) draw_start = 1'b0;
    chk("start_first_byte", {busy, byte_valid, byte_dc, byte_data}, {1'b1, 1'b1, 1'b0, 8'h2A});
    while (!fin) begin
      if (cyc > 5000) begin
        chk("frame_timeout", 32'(n), 32'(NB));
        break;
      end
      if (held) chk("hold_stable", {byte_valid, byte_dc, byte_data}, {1'b1, held_v});
      chk("busy_in_frame", {busy, done}, 2'b10);
      if (n == stop_at && stop_mode == 1) begin
        byte_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_idle", {byte_valid, busy, done, dbg_state == ST_IDLE}, 4'b0001);
        @(negedge clk);
        chk("abort_no_done", {byte_valid, busy, done}, 3'b000);
        exp_q.delete();
        return;
      end
      if (n == stop_at && stop_mode == 2) begin
        byte_ready = 1'b0;
        #2 reset = 1'b0;
        #1 chk("async_reset_out", {byte_valid, byte_dc, byte_data, busy, done}, 32'd0);
        chk("async_reset_state", 32'(dbg_state == ST_IDLE), 32'd1);
        @(negedge clk) reset = 1'b1;
        exp_q.delete();
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      byte_ready = rdy;
      draw_start = poke && (n == 30);
      if (poke && n == 30) color_a = ~color_a;
      held = 1'b0;
      if (byte_valid) begin
        if (rdy) begin
          if (exp_q.size() == 0) chk("extra_byte", {byte_dc, byte_data}, 32'h1FF);
          else chk("stream_byte", {byte_dc, byte_data}, exp_q.pop_front());
          got.push_back({byte_dc, byte_data});
          n++;
          if (n == NB) fin = 1'b1;
        end else begin
          held = 1'b1;
          held_v = {byte_dc, byte_data};
        end
      end
      @(negedge clk);
      cyc++;
    end
    draw_start = 1'b0;
    byte_ready = 1'b0;
    chk("byte_count", 32'(n), 32'(NB));
    chk("done_pulse", {byte_valid, busy, done}, 3'b001);
    @(negedge clk);
    chk("done_drop", {byte_valid, busy, done, dbg_state == ST_IDLE}, 4'b0001);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("reset_outputs", {byte_valid, byte_dc, byte_data, busy, done}, 32'd0);
    chk("reset_state", 32'(dbg_state == ST_IDLE), 32'd1);
    @(negedge clk) reset = 1'b1;

    // Full frame, always ready; header bytes checked by hand too.
    color_a = 16'hF800; color_b = 16'h001F; line_color = 16'hFFFF;
    push_frame(color_a, color_b, line_color);
    run_frame(100, -1, 0, 1'b0);
    chk("frame_size", 32'(got.size()), 32'd75);
    if (got.size() == 75) begin
      chk("hdr_caset", got[0], 9'h02A);
      chk("hdr_w_last", got[4], 9'h107);
      chk("hdr_h_last", got[9], 9'h103);
      chk("hdr_ramwr", got[10], 9'h02C);
`ifndef LCD_GRID_LINES_EN
      chk("pix_0_0", {got[11], got[12]}, {9'h1F8, 9'h100});
      chk("pix_4_0", {got[19], got[20]}, {9'h100, 9'h11F});
      chk("pix_4_2", {got[51], got[52]}, {9'h1F8, 9'h100});
      chk("pix_7_3", {got[73], got[74]}, {9'h1F8, 9'h100});
`endif
    end

`ifdef LCD_GRID_LINES_EN
    color_b = 16'h07E0;
    push_frame(color_a, color_b, line_color);
    run_frame(100, -1, 0, 1'b0);
    if (got.size() == 75) begin
      chk("line_0_1", {got[27], got[28]}, {9'h1FF, 9'h1FF});
      chk("cell_1_1", {got[29], got[30]}, {9'h1F8, 9'h100});
      chk("line_4_1", {got[35], got[36]}, {9'h1FF, 9'h1FF});
      chk("cell_5_1", {got[37], got[38]}, {9'h107, 9'h1E0});
      chk("line_7_2", {got[57], got[58]}, {9'h1FF, 9'h1FF});
    end
    color_b = 16'h001F;
`endif

    // draw_start together with abort in IDLE: nothing starts.
    @(negedge clk) begin draw_start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin draw_start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle", {byte_valid, busy, done, dbg_state == ST_IDLE}, 4'b0001);
    @(negedge clk);
    chk("start_abort_stay", {byte_valid, busy, done}, 3'b000);

    // Random backpressure, mid-frame start pulse and colour change must not disturb the stream.
    push_frame(color_a, color_b, line_color);
    run_frame(30, -1, 0, 1'b1);
    color_a = 16'hF800;

    // Abort after 20 transfers, then a full replay.
    push_frame(color_a, color_b, line_color);
    run_frame(100, 20, 1, 1'b0);
    push_frame(color_a, color_b, line_color);
    run_frame(100, -1, 0, 1'b0);

    // Asynchronous reset at byte 40, then a full frame.
    push_frame(color_a, color_b, line_color);
    run_frame(70, 40, 2, 1'b0);
    push_frame(color_a, color_b, line_color);
    run_frame(100, -1, 0, 1'b0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
